// File: rtl/mvu_job_ctrl.sv
// Per-MVU job sequencer: latches one bit-serial job on start and emits the
// accumulator, AGU and quantizer control strobes for it, cycle by cycle.
module mvu_job_ctrl #(
    parameter int unsigned BPREC    = 6,
    parameter int unsigned BCNTDWN  = 29,
    parameter int unsigned BQMSBIDX = 5,
    parameter int unsigned QDRAIN   = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                stall,
    input  logic [BPREC-1:0]    cfg_wprecision,
    input  logic [BPREC-1:0]    cfg_iprecision,
    input  logic [BCNTDWN-1:0]  cfg_countdown,
    input  logic [BQMSBIDX-1:0] cfg_quant_msbidx,
    output logic                busy,
    output logic                done,
    output logic                agu_en,
    output logic                acc_clr,
    output logic                acc_sh,
    output logic                quant_clr,
    output logic                quant_start,
    output logic [BQMSBIDX-1:0] quant_msbidx
);

    localparam int unsigned BDRAIN = (QDRAIN > 1) ? $clog2(QDRAIN) : 1;

    typedef enum logic [2:0] {StIdle, StClr, StRun, StDrain, StDone} state_e;

    state_e               state_q, state_d;
    logic [BPREC-1:0]     wprec_q, iprec_q;
    logic [BPREC-1:0]     wcnt_q, wcnt_d, icnt_q, icnt_d;
    logic [BCNTDWN-1:0]   countdown_q, remaining_q, remaining_d;
    logic [BQMSBIDX-1:0]  msbidx_q;
    logic [BDRAIN-1:0]    drain_q, drain_d;
    logic                 quant_start_q, quant_start_d;

    logic                 accept, zero_job;
    logic [BPREC-1:0]     wprec_m1, iprec_m1;
    logic                 i_end, w_end, vec_end, last, first_plane;

    assign accept   = (state_q == StIdle) && start;
    assign zero_job = (cfg_countdown == '0) || (cfg_wprecision == '0) || (cfg_iprecision == '0);

    assign wprec_m1    = wprec_q - BPREC'(1);
    assign iprec_m1    = iprec_q - BPREC'(1);
    assign i_end       = (icnt_q == iprec_m1);
    assign w_end       = (wcnt_q == wprec_m1);
    assign vec_end     = i_end && w_end;
    assign last        = vec_end || (remaining_q == BCNTDWN'(1));
    assign first_plane = (wcnt_q == '0) && (icnt_q == '0);

    always_comb begin
        state_d       = state_q;
        wcnt_d        = wcnt_q;
        icnt_d        = icnt_q;
        remaining_d   = remaining_q;
        drain_d       = drain_q;
        quant_start_d = 1'b0;
        agu_en        = 1'b0;
        acc_clr       = 1'b0;
        acc_sh        = 1'b0;

        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = zero_job ? StDone : StClr;
                end
            end
            StClr: begin
                acc_clr     = 1'b1;
                wcnt_d      = '0;
                icnt_d      = '0;
                remaining_d = countdown_q;
                state_d     = StRun;
            end
            StRun: begin
                if (!stall) begin
                    agu_en        = 1'b1;
                    acc_clr       = first_plane;
                    acc_sh        = !first_plane;
                    quant_start_d = last;
                    if (remaining_q != '0) begin
                        remaining_d = remaining_q - BCNTDWN'(1);
                    end
                    // icnt is the inner (input bit) loop, wcnt the outer one.
                    if (i_end) begin
                        icnt_d = '0;
                        wcnt_d = w_end ? '0 : wcnt_q + BPREC'(1);
                    end else begin
                        icnt_d = icnt_q + BPREC'(1);
                    end
                    if (remaining_q == BCNTDWN'(1)) begin
                        drain_d = '0;
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                if (drain_q == BDRAIN'(QDRAIN - 1)) begin
                    state_d = StDone;
                end else begin
                    drain_d = drain_q + BDRAIN'(1);
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            wprec_q       <= '0;
            iprec_q       <= '0;
            countdown_q   <= '0;
            msbidx_q      <= '0;
            wcnt_q        <= '0;
            icnt_q        <= '0;
            remaining_q   <= '0;
            drain_q       <= '0;
            quant_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wcnt_q        <= wcnt_d;
            icnt_q        <= icnt_d;
            remaining_q   <= remaining_d;
            drain_q       <= drain_d;
            quant_start_q <= quant_start_d;
            if (accept) begin
                wprec_q     <= cfg_wprecision;
                iprec_q     <= cfg_iprecision;
                countdown_q <= cfg_countdown;
                msbidx_q    <= cfg_quant_msbidx;
            end
        end
    end

    assign busy         = (state_q == StClr) || (state_q == StRun) || (state_q == StDrain);
    assign done         = (state_q == StDone);
    assign quant_clr    = (state_q == StClr);
    assign quant_start  = quant_start_q;
    assign quant_msbidx = msbidx_q;

endmodule
